// File: rtl/calc_nport.sv
// calc_nport: multi-port two-operand calculator sharing one round-robin arbitrated ALU.
// Define CALC_SHIFT_EN to add logical shift commands 5 (<<) and 6 (>>).
module calc_nport #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32
) (
   input  logic                        c_clk,
   input  logic                        reset,
   input  logic [4*NUM_PORTS-1:0]      req_cmd_in,
   input  logic [DATA_W*NUM_PORTS-1:0] req_data_in,
   output logic [2*NUM_PORTS-1:0]      out_resp,
   output logic [DATA_W*NUM_PORTS-1:0] out_data
);
   localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   localparam logic [1:0] IDLE = 2'd0, OP2 = 2'd1, READY = 2'd2;
   logic [NUM_PORTS-1:0][1:0]        st_q, st_d;
   logic [NUM_PORTS-1:0][3:0]        cmd_q, cmd_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [NUM_PORTS-1:0][1:0]        resp_q, resp_d;
   logic [NUM_PORTS-1:0][DATA_W-1:0] res_q, res_d;
   logic [PW-1:0]                    last_q, last_d, gnt, idx;
   logic                             gnt_v;
   logic [3:0]                       op;
   logic [DATA_W-1:0]                a, b, alu_data;
   logic [DATA_W:0]                  sum;
   logic [1:0]                       alu_resp;

   always_ff @(posedge c_clk or posedge reset)
      if (reset) begin
         st_q   <= '0;
         cmd_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         resp_q <= '0;
         res_q  <= '0;
         last_q <= PW'(NUM_PORTS - 1);
      end else begin
         st_q   <= st_d;
         cmd_q  <= cmd_d;
         a_q    <= a_d;
         b_q    <= b_d;
         resp_q <= resp_d;
         res_q  <= res_d;
         last_q <= last_d;
      end

   // Search starts one past the last grant so every READY port is served within NUM_PORTS cycles.
   always_comb begin
      gnt_v = 1'b0;
      gnt   = last_q;
      idx   = last_q;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = PW'((int'(last_q) + i) % NUM_PORTS);
         if (!gnt_v && st_q[idx] == READY) begin
            gnt_v = 1'b1;
            gnt   = idx;
         end
      end
   end

   assign op  = cmd_q[gnt];
   assign a   = a_q[gnt];
   assign b   = b_q[gnt];
   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      alu_resp = 2'd3;
      alu_data = '0;
      if (op == 4'd1) begin
         alu_resp = sum[DATA_W] ? 2'd2 : 2'd1;
         alu_data = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
      end else if (op == 4'd2) begin
         alu_resp = b > a ? 2'd2 : 2'd1;
         alu_data = b > a ? '0 : a - b;
      end
`ifdef CALC_SHIFT_EN
      else if (op == 4'd5) begin
         alu_resp = 2'd1;
         alu_data = a << b[$clog2(DATA_W)-1:0];
      end else if (op == 4'd6) begin
         alu_resp = 2'd1;
         alu_data = a >> b[$clog2(DATA_W)-1:0];
      end
`endif
   end

   always_comb begin
      st_d   = st_q;
      cmd_d  = cmd_q;
      a_d    = a_q;
      b_d    = b_q;
      last_d = gnt_v ? gnt : last_q;
      for (int p = 0; p < NUM_PORTS; p++)
         if (st_q[p] == IDLE && req_cmd_in[4*p+:4] != 4'd0) begin
            st_d[p]  = OP2;
            cmd_d[p] = req_cmd_in[4*p+:4];
            a_d[p]   = req_data_in[DATA_W*p+:DATA_W];
         end else if (st_q[p] == OP2) begin
            st_d[p] = READY;
            b_d[p]  = req_data_in[DATA_W*p+:DATA_W];
         end else if (st_q[p] == READY && gnt_v && gnt == PW'(p))
            st_d[p] = IDLE;
   end

   always_comb begin
      resp_d = '0;
      res_d  = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (gnt_v && gnt == PW'(p)) begin
            resp_d[p] = alu_resp;
            res_d[p]  = alu_data;
         end
   end

   assign out_resp = resp_q;
   assign out_data = res_q;
endmodule

// File: tb/tb_calc_nport.sv
// tb_calc_nport: vector table, directed arbitration/reset sequences and random traffic
// checked every cycle against a transaction-level model of calc_nport.
module tb_calc_nport;
   localparam int NP = 4;
   localparam int DW = 32;
`ifdef CALC_SHIFT_EN
   localparam bit SH = 1'b1;
`else
   localparam bit SH = 1'b0;
`endif
   logic            c_clk = 1'b0;
   logic            reset = 1'b1;
   logic [4*NP-1:0] req_cmd_in = '0;
   logic [DW*NP-1:0] req_data_in = '0;
   logic [2*NP-1:0] out_resp;
   logic [DW*NP-1:0] out_data;
   int n_cmp = 0, n_bad = 0;
   int          ph[NP];
   logic [3:0]  mc[NP];
   longint      ma[NP], mb[NP];
   int          last;
   logic [1:0]  er[NP];
   logic [31:0] ed[NP];

   typedef struct {
      int          port;
      logic [3:0]  cmd;
      logic [31:0] op1, op2;
      logic [1:0]  r;
      logic [31:0] d;
   } vec_t;
   vec_t vt[8];

   calc_nport #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
      .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in),
      .req_data_in(req_data_in), .out_resp(out_resp), .out_data(out_data)
   );

   always #5 c_clk = ~c_clk;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic clr();
      req_cmd_in  = '0;
      req_data_in = '0;
   endtask

   task automatic set(input int p, input logic [3:0] c, input logic [31:0] d);
      req_cmd_in[4*p+:4]   = c;
      req_data_in[32*p+:32] = d;
   endtask

   task automatic model_clear();
      for (int p = 0; p < NP; p++) begin
         ph[p] = 0;
         er[p] = '0;
         ed[p] = '0;
      end
      last = NP - 1;
   endtask

   task automatic alu(input logic [3:0] c, input longint a, input longint b,
                      output int r, output longint d);
      r = 3;
      d = 0;
      if (c == 4'd1) begin
         if (a + b > 64'hFFFF_FFFF) r = 2;
         else begin r = 1; d = a + b; end
      end else if (c == 4'd2) begin
         if (b > a) r = 2;
         else begin r = 1; d = a - b; end
      end else if (SH && c == 4'd5) begin
         r = 1; d = (a << (b % 32)) & 64'hFFFF_FFFF;
      end else if (SH && c == 4'd6) begin
         r = 1; d = a >> (b % 32);
      end
   endtask

   // Compare this cycle's outputs, then advance the model across the coming edge.
   task automatic tick();
      int g, r, q;
      int oph[NP];
      longint d;
      logic [3:0] c;
      @(negedge c_clk);
      for (int p = 0; p < NP; p++) begin
         check($sformatf("resp p%0d", p), out_resp[2*p+:2], er[p]);
         check($sformatf("data p%0d", p), out_data[32*p+:32], ed[p]);
      end
      oph = ph;
      g = -1;
      for (int i = 1; i <= NP; i++) begin
         q = (last + i) % NP;
         if (g < 0 && oph[q] == 2) g = q;
      end
      for (int p = 0; p < NP; p++) begin
         er[p] = '0;
         ed[p] = '0;
         c = req_cmd_in[4*p+:4];
         if (oph[p] == 0 && c != 4'd0) begin
            ph[p] = 1; mc[p] = c; ma[p] = {32'd0, req_data_in[32*p+:32]};
         end else if (oph[p] == 1) begin
            ph[p] = 2; mb[p] = {32'd0, req_data_in[32*p+:32]};
         end
      end
      if (g >= 0) begin
         alu(mc[g], ma[g], mb[g], r, d);
         er[g] = 2'(r);
         ed[g] = 32'(d);
         ph[g] = 0;
         last  = g;
      end
      @(posedge c_clk);
      #1;
   endtask

   task automatic pulse_reset(input string nm);
      #2 reset = 1'b1;
      #1;
      check({nm, " resp"}, out_resp, '0);
      check({nm, " data"}, out_data, '0);
      @(posedge c_clk);
      #1 reset = 1'b0;
      model_clear();
   endtask

   initial begin
      vt[0] = '{0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
      vt[1] = '{1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0};
      vt[2] = '{2, 4'd2, 32'd5, 32'd6, 2'd2, 32'h0};
      vt[3] = '{2, 4'd2, 32'd6, 32'd6, 2'd1, 32'h0};
      vt[4] = '{3, 4'd5, 32'h0000_0001, 32'h0000_0024, SH ? 2'd1 : 2'd3, SH ? 32'h10 : 32'h0};
      vt[5] = '{0, 4'd9, 32'd3, 32'd4, 2'd3, 32'h0};
      vt[6] = '{1, 4'd2, 32'd10, 32'd3, 2'd1, 32'd7};
      vt[7] = '{3, 4'd6, 32'h80, 32'h24, SH ? 2'd1 : 2'd3, SH ? 32'h8 : 32'h0};
      model_clear();
      #1;
      check("reset resp", out_resp, '0);
      check("reset data", out_data, '0);
      @(posedge c_clk);
      @(posedge c_clk);
      #1 reset = 1'b0;
      // Junk commands during OP2/READY must be ignored.
      foreach (vt[k]) begin
         clr(); set(vt[k].port, vt[k].cmd, vt[k].op1); tick();
         clr(); set(vt[k].port, 4'd1, vt[k].op2); tick();
         clr(); set(vt[k].port, 4'd1, 32'hDEAD_BEEF); tick();
         clr();
         check($sformatf("vec%0d resp", k), out_resp[2*vt[k].port+:2], vt[k].r);
         check($sformatf("vec%0d data", k), out_data[32*vt[k].port+:32], vt[k].d);
      end
      tick();
      for (int p = 0; p < NP; p++) set(p, 4'd1, 32'd1);
      tick();
      for (int p = 0; p < NP; p++) set(p, 4'd0, 32'd1);
      tick();
      clr(); tick();
      for (int p = 0; p < NP; p++) begin
         check($sformatf("contend resp p%0d", p), out_resp[2*p+:2], 2'd1);
         check($sformatf("contend data p%0d", p), out_data[32*p+:32], 32'd2);
         tick();
      end
      set(3, 4'd1, 32'd5); set(0, 4'd1, 32'd7); tick();
      set(3, 4'd0, 32'd6); set(0, 4'd0, 32'd8); tick();
      clr(); tick();
      check("rr first p0", out_resp[1:0], 2'd1);
      check("rr first p3 idle", out_resp[7:6], 2'd0);
      check("rr first data", out_data[31:0], 32'd15);
      tick();
      check("rr second p3", out_resp[7:6], 2'd1);
      check("rr second data", out_data[127:96], 32'd11);
      tick();
      set(0, 4'd1, 32'd3); tick();
      set(0, 4'd0, 32'd4); tick();
      clr();
      pulse_reset("ready abort");
      repeat (4) tick();
      set(2, 4'd1, 32'd10); tick();
      set(2, 4'd0, 32'd20); tick();
      clr(); tick();
      check("post reset resp", out_resp[5:4], 2'd1);
      check("post reset data", out_data[95:64], 32'd30);
      set(1, 4'd2, 32'd9); tick();
      set(1, 4'd0, 32'd4); tick();
      clr(); tick();
      check("pre abort resp", out_resp[3:2], 2'd1);
      pulse_reset("resp abort");
      repeat (3) tick();
      for (int n = 0; n < 400; n++) begin
         for (int p = 0; p < NP; p++) begin
            int r;
            logic [31:0] d;
            r = int'($urandom_range(0, 9));
            d = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF :
                $urandom_range(0, 2) == 0 ? 32'($urandom_range(0, 40)) : 32'($urandom);
            set(p, r < 5 ? 4'd0 : r < 7 ? 4'd1 : r < 9 ? 4'd2 : 4'($urandom_range(3, 15)), d);
         end
         tick();
      end
      clr();
      repeat (8) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
